// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: RAM-backed N-point complex frame source with a valid/ready output stage.
// Define FFS_BITREV_EN to enable bit-reversed read order through the bitrev input.

module fft_frame_streamer #(
    parameter int DW     = 12,
    parameter int LOG2N  = 8,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [LOG2N-1:0]  wr_addr,
    input  logic [DW-1:0]     wr_re,
    input  logic [DW-1:0]     wr_im,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic              bitrev,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_re,
    output logic [DW-1:0]     out_im,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    logic [LOG2N-1:0] ptr;
    logic [LOG2N-1:0] rd_addr;
    logic             stop_req;
    logic             issue;
    logic             last_issue;
    logic             pop;

    logic [2*DW-1:0]  mem [N];
    logic [2*DW-1:0]  rd_word;
    logic             rd_valid;
    logic             rd_sof;
    logic             rd_eof;

    logic [2*DW-1:0]  skid_word;
    logic             skid_valid;
    logic             skid_sof;
    logic             skid_eof;

    assign pop        = out_valid & out_ready;
    assign issue      = (state == RUN) & (~out_valid | out_ready);
    assign last_issue = issue & (ptr == LAST_IDX);

`ifdef FFS_BITREV_EN
    logic rev_mode;

    function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    assign rd_addr = rev_mode ? bit_reverse(ptr) : ptr;
`else
    logic unused_bitrev;
    assign unused_bitrev = bitrev;
    assign rd_addr       = ptr;
`endif

    // Control FSM; continuous/bitrev are only looked at on frame start and pointer wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ptr       <= '0;
            stop_req  <= 1'b0;
            frame_cnt <= '0;
`ifdef FFS_BITREV_EN
            rev_mode  <= 1'b0;
`endif
        end else begin
            if (pop && out_eof) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        ptr      <= '0;
                        stop_req <= stop;
`ifdef FFS_BITREV_EN
                        rev_mode <= bitrev;
`endif
                    end
                end
                RUN: begin
                    if (stop) begin
                        stop_req <= 1'b1;
                    end
                    if (issue) begin
                        ptr <= ptr + LOG2N'(1);
                    end
                    if (last_issue) begin
                        if (stop_req || stop || !continuous) begin
                            state <= DRAIN;
                        end
`ifdef FFS_BITREV_EN
                        rev_mode <= bitrev;
`endif
                    end
                end
                DRAIN: begin
                    if (pop && out_eof) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Frame RAM: write-anywhere, synchronous read-first read port driven by the read pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_re, wr_im};
        end
        if (issue) begin
            rd_word <= mem[rd_addr];
            rd_sof  <= (ptr == '0);
            rd_eof  <= (ptr == LAST_IDX);
        end
    end

    // Output register plus skid entry; the older skid entry always drains before new RAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            skid_valid <= 1'b0;
            skid_word  <= '0;
            skid_sof   <= 1'b0;
            skid_eof   <= 1'b0;
            out_valid  <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
        end else begin
            rd_valid <= issue;
            if (pop || !out_valid) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_re     <= skid_word[2*DW-1:DW];
                    out_im     <= skid_word[DW-1:0];
                    out_sof    <= skid_sof;
                    out_eof    <= skid_eof;
                    skid_valid <= rd_valid;
                    skid_word  <= rd_word;
                    skid_sof   <= rd_sof;
                    skid_eof   <= rd_eof;
                end else if (rd_valid) begin
                    out_valid <= 1'b1;
                    out_re    <= rd_word[2*DW-1:DW];
                    out_im    <= rd_word[DW-1:0];
                    out_sof   <= rd_sof;
                    out_eof   <= rd_eof;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (rd_valid) begin
                skid_valid <= 1'b1;
                skid_word  <= rd_word;
                skid_sof   <= rd_sof;
                skid_eof   <= rd_eof;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb_fft_frame_streamer: directed self-checking bench for fft_frame_streamer (N=256, 2-bit frame counter).
// Expected samples come from a bench-side RAM image; bit-reversed order is expected only with FFS_BITREV_EN.

module tb_fft_frame_streamer;

    localparam int DW     = 12;
    localparam int LOG2N  = 8;
    localparam int FCNT_W = 2;
    localparam int N      = 1 << LOG2N;
`ifdef FFS_BITREV_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [LOG2N-1:0]  wr_addr;
    logic [DW-1:0]     wr_re;
    logic [DW-1:0]     wr_im;
    logic              start;
    logic              stop;
    logic              continuous;
    logic              bitrev;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_re;
    logic [DW-1:0]     out_im;
    logic              out_sof;
    logic              out_eof;
    logic              busy;
    logic [FCNT_W-1:0] frame_cnt;

    int num_checks = 0;
    int num_fails  = 0;

    logic [2*DW-1:0]   ram_model [N];
    int                exp_pos;
    logic [FCNT_W-1:0] exp_frames;
    logic              exp_rev;
    logic              pend_valid;
    logic [LOG2N-1:0]  pend_addr;
    logic [2*DW-1:0]   pend_word;

    fft_frame_streamer #(
        .DW     (DW),
        .LOG2N  (LOG2N),
        .FCNT_W (FCNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_re      (wr_re),
        .wr_im      (wr_im),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .bitrev     (bitrev),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic c, input logic b);
        start      = s;
        stop       = p;
        continuous = c;
        bitrev     = b;
    endtask

    function automatic logic [LOG2N-1:0] brev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    function automatic logic [2*DW-1:0] expWord(input int pos);
        logic [LOG2N-1:0] a;
        a = LOG2N'(pos);
        if (exp_rev) a = brev(a);
        return ram_model[a];
    endfunction

    task automatic loadRam();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            wr_en        = 1'b1;
            wr_addr      = LOG2N'(k);
            wr_re        = DW'(k);
            wr_im        = DW'(-k);
            ram_model[k] = {DW'(k), DW'(-k)};
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic writeRam(input int addr, input logic [DW-1:0] re, input logic [DW-1:0] im);
        @(negedge clk);
        wr_en           = 1'b1;
        wr_addr         = LOG2N'(addr);
        wr_re           = re;
        wr_im           = im;
        ram_model[addr] = {re, im};
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulses start (optionally with stop) and checks busy/out_valid over the two-cycle start-up.
    task automatic startFrame(input logic p, input logic c, input logic b);
        @(negedge clk);
        wr_en = 1'b0;
        applyStimulus(1'b1, p, c, b);
        exp_rev = b & REV_EN;
        exp_pos = 0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, c, b);
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        checkOutput("valid_one_after_start", 64'(out_valid), 64'(0));
        @(negedge clk);
        checkOutput("valid_two_after_start", 64'(out_valid), 64'(0));
    endtask

    // Receives nxfer transfers and checks each against the model, plus stall stability and bubbles.
    task automatic streamCheck(input int nxfer, input bit rand_ready, input int start_at,
                               input int stop_at, input bit inject);
        int                got = 0;
        int                cycles = 0;
        bit                start_done = 1'b0;
        bit                stop_done = 1'b0;
        bit                prev_stall = 1'b0;
        bit                first = 1'b1;
        logic [2*DW+2:0]   prev_fields = '0;
        while (got < nxfer) begin
            @(negedge clk);
            cycles++;
            if (cycles > nxfer * 4 + 50) begin
                checkOutput("stream_timeout", 64'(got), 64'(nxfer));
                break;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 1'b0;
            stop  = 1'b0;
            wr_en = 1'b0;
            if (!start_done && got == start_at) begin
                start      = 1'b1;
                start_done = 1'b1;
            end
            if (!stop_done && got == stop_at) begin
                stop      = 1'b1;
                stop_done = 1'b1;
            end
            if (first) checkOutput("first_sample_latency", 64'(out_valid), 64'(1));
            first = 1'b0;
            if (prev_stall)
                checkOutput("stall_stable", 64'({out_valid, out_sof, out_eof, out_re, out_im}), 64'(prev_fields));
            if (!rand_ready && got > 0) checkOutput("no_bubble", 64'(out_valid), 64'(1));
            if (out_valid && out_ready) begin
                if (inject && got == 8) begin
                    wr_en      = 1'b1;
                    wr_addr    = LOG2N'(10);
                    wr_re      = 12'h7FF;
                    wr_im      = 12'h000;
                    pend_valid = 1'b1;
                    pend_addr  = LOG2N'(10);
                    pend_word  = {12'h7FF, 12'h000};
                end
                checkOutput("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
                checkOutput($sformatf("sample%0d", exp_pos), 64'({out_re, out_im}), 64'(expWord(exp_pos)));
                checkOutput("sof", 64'(out_sof), 64'(exp_pos == 0));
                checkOutput("eof", 64'(out_eof), 64'(exp_pos == N - 1));
                got++;
                exp_pos++;
                if (exp_pos == N) begin
                    exp_pos    = 0;
                    exp_frames = exp_frames + 1'b1;
                    if (pend_valid) begin
                        ram_model[pend_addr] = pend_word;
                        pend_valid           = 1'b0;
                    end
                end
            end
            prev_stall  = out_valid && !out_ready;
            prev_fields = {out_valid, out_sof, out_eof, out_re, out_im};
        end
    endtask

    task automatic endCheck();
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        checkOutput("busy_after_eof", 64'(busy), 64'(0));
        checkOutput("valid_after_eof", 64'(out_valid), 64'(0));
        checkOutput("frame_cnt_after_eof", 64'(frame_cnt), 64'(exp_frames));
        repeat (4) @(negedge clk);
        checkOutput("still_idle", 64'({busy, out_valid}), 64'(0));
    endtask

    task automatic modelReset();
        exp_pos    = 0;
        exp_frames = '0;
        exp_rev    = 1'b0;
        pend_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_re     = '0;
        wr_im     = '0;
        out_ready = 1'b0;
        pend_addr = '0;
        pend_word = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_frame_cnt", 64'(frame_cnt), 64'(0));
        checkOutput("reset_data", 64'({out_re, out_im}), 64'(0));
        checkOutput("reset_markers", 64'({out_sof, out_eof}), 64'(0));
        rst = 1'b0;
        loadRam();

        // Single shot, ready always high; start pulsed mid-frame must be ignored.
        out_ready = 1'b1;
        startFrame(1'b0, 1'b0, 1'b0);
        streamCheck(N, 1'b0, 50, -1, 1'b0);
        endCheck();
        checkOutput("frames_after_first", 64'(frame_cnt), 64'(1));

        // Single shot with random backpressure.
        startFrame(1'b0, 1'b0, 1'b0);
        streamCheck(N, 1'b1, -1, -1, 1'b0);
        endCheck();

        // Bit-reverse request: reversed order only when the feature is built in.
        out_ready = 1'b1;
        startFrame(1'b0, 1'b0, 1'b1);
        streamCheck(N, 1'b0, -1, -1, 1'b0);
        endCheck();

        // start and stop together in IDLE with continuous set: exactly one frame; counter wraps to 0.
        startFrame(1'b1, 1'b1, 1'b0);
        streamCheck(N, 1'b0, -1, -1, 1'b0);
        endCheck();
        checkOutput("frame_cnt_wrap", 64'(frame_cnt), 64'(0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous frames, stop during the fifth; RAM[10] rewritten as it is read in frame one.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        startFrame(1'b0, 1'b1, 1'b0);
        streamCheck(5 * N, 1'b0, -1, 4 * N + 100, 1'b1);
        endCheck();
        checkOutput("frame_cnt_after_five", 64'(frame_cnt), 64'(1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame keeps RAM contents.
        writeRam(0, 12'h123, 12'h456);
        startFrame(1'b0, 1'b0, 1'b0);
        streamCheck(101, 1'b0, -1, -1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_valid", 64'(out_valid), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_frame_cnt", 64'(frame_cnt), 64'(0));
        rst = 1'b0;
        modelReset();
        startFrame(1'b0, 1'b0, 1'b0);
        streamCheck(N, 1'b0, -1, -1, 1'b0);
        endCheck();

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
